// File: rtl/mdu_div_pkg.sv
// Shared types and constants for the iterative MDU divider.
package mdu_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_W = 32;
  localparam int DIV_CNT_W = $clog2(DIV_W + 1);
  localparam logic [DIV_W-1:0] DIV_DZ_QUO = '1;

endpackage

// File: rtl/mdu_div_step.sv
// One radix-2 restoring step: shift in a dividend bit, trial-subtract, keep or restore.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  always_comb begin
    shifted = {rem_in[WIDTH-1:0], bit_in};
    // A set top bit means the true shifted value exceeds any divisor.
    q_bit   = rem_in[WIDTH] || (shifted >= {1'b0, divisor});
    rem_out = q_bit ? (shifted - {1'b0, divisor}) : shifted;
  end

endmodule

// File: rtl/mdu_iter_div.sv
// Iterative restoring divider with the divider stream responder interface.
module mdu_iter_div
  import mdu_div_pkg::*;
#(
  parameter int SIGNED = 1,
  parameter int WIDTH  = DIV_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tvalid
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] raw_dvd;
  logic             q_neg;
  logic             r_neg;
  logic             dz;
  logic             accept;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;

  assign s_axis_dividend_tready = (state == IDLE) && !rst;
  assign s_axis_divisor_tready  = s_axis_dividend_tready;
  assign accept = (state == IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;

  // Unsigned magnitudes; -2^(W-1) maps to 2^(W-1), which is exact as unsigned.
  always_comb begin
    dvd_neg = (SIGNED != 0) && s_axis_dividend_tdata[WIDTH-1];
    dvs_neg = (SIGNED != 0) && s_axis_divisor_tdata[WIDTH-1];
    dvd_abs = dvd_neg ? ('0 - s_axis_dividend_tdata) : s_axis_dividend_tdata;
    dvs_abs = dvs_neg ? ('0 - s_axis_divisor_tdata) : s_axis_divisor_tdata;
  end

  always_comb begin
    q_out = q_neg ? ('0 - quo) : quo;
    r_out = r_neg ? ('0 - rem[WIDTH-1:0]) : rem[WIDTH-1:0];
  end

  mdu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .divisor (dvs),
    .bit_in  (quo[WIDTH-1]),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // quo starts as the dividend magnitude and shifts quotient bits in from the right.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= '0;
      rem                <= '0;
      quo                <= '0;
      dvs                <= '0;
      raw_dvd            <= '0;
      q_neg              <= 1'b0;
      r_neg              <= 1'b0;
      dz                 <= 1'b0;
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tdata  <= '0;
    end else begin
      m_axis_dout_tvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rem     <= '0;
            quo     <= dvd_abs;
            dvs     <= dvs_abs;
            raw_dvd <= s_axis_dividend_tdata;
            q_neg   <= dvd_neg ^ dvs_neg;
            r_neg   <= dvd_neg;
            dz      <= (s_axis_divisor_tdata == '0);
            cnt     <= CNT_W'(WIDTH);
            state   <= CALC;
          end
        end
        CALC: begin
          rem <= step_rem;
          quo <= {quo[WIDTH-2:0], step_q};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          m_axis_dout_tvalid <= 1'b1;
          // Divide by zero reports the raw dividend, bypassing sign correction.
          if (dz) begin
            m_axis_dout_tdata <= {{WIDTH{1'b1}}, raw_dvd};
          end else begin
            m_axis_dout_tdata <= {q_out, r_out};
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter_div.sv
// Self-checking bench: signed and unsigned dividers side by side against an arithmetic model.
module tb_mdu_iter_div;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         a_v;
  logic         b_v;
  logic         a_rdy_s, b_rdy_s, a_rdy_u, b_rdy_u;
  logic         v_s, v_u;
  logic [2*W-1:0] d_s, d_u;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mdu_iter_div #(.SIGNED(1), .WIDTH(W)) dut_s (
    .clk                    (clk),
    .rst                    (rst),
    .s_axis_dividend_tdata  (a),
    .s_axis_dividend_tvalid (a_v),
    .s_axis_dividend_tready (a_rdy_s),
    .s_axis_divisor_tdata   (b),
    .s_axis_divisor_tvalid  (b_v),
    .s_axis_divisor_tready  (b_rdy_s),
    .m_axis_dout_tdata      (d_s),
    .m_axis_dout_tvalid     (v_s)
  );

  mdu_iter_div #(.SIGNED(0), .WIDTH(W)) dut_u (
    .clk                    (clk),
    .rst                    (rst),
    .s_axis_dividend_tdata  (a),
    .s_axis_dividend_tvalid (a_v),
    .s_axis_dividend_tready (a_rdy_u),
    .s_axis_divisor_tdata   (b),
    .s_axis_divisor_tvalid  (b_v),
    .s_axis_divisor_tready  (b_rdy_u),
    .m_axis_dout_tdata      (d_u),
    .m_axis_dout_tvalid     (v_u)
  );

  // MIPS semantics: truncating quotient, remainder takes the dividend's sign.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] x, input logic [31:0] y);
    longint q, r, sx, sy;
    if (y == 32'd0) return {32'hFFFF_FFFF, x};
    if (sgn) begin
      sx = longint'(signed'(x));
      sy = longint'(signed'(y));
    end else begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end
    q = sx / sy;
    r = sx % sy;
    return {q[31:0], r[31:0]};
  endfunction

  // Caller stands 1 time unit after an edge with both dividers idle.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input bit hold);
    a = x; b = y; a_v = 1'b1; b_v = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin
      a_v = 1'b0; b_v = 1'b0;
    end
  endtask

  // Observes edges k+1 .. k+W+1 after an accept at edge k.
  task automatic collect(output bit busy_ok, output bit pulse,
                         output logic [63:0] ds, output logic [63:0] du);
    busy_ok = !(a_rdy_s || b_rdy_s || a_rdy_u || b_rdy_u);
    for (int n = 1; n <= W; n++) begin
      @(posedge clk); #1;
      if (a_rdy_s || b_rdy_s || a_rdy_u || b_rdy_u || v_s || v_u) busy_ok = 1'b0;
    end
    @(posedge clk); #1;
    pulse = v_s && v_u && a_rdy_s && b_rdy_s && a_rdy_u && b_rdy_u;
    ds = d_s;
    du = d_u;
  endtask

  task automatic test_reset();
    rst = 1'b1; a = '0; b = '0; a_v = 1'b0; b_v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({a_rdy_s, b_rdy_s, a_rdy_u, b_rdy_u} !== 4'b0000) begin
      bad++; $display("FAIL reset_tready: got %b want 0000", {a_rdy_s, b_rdy_s, a_rdy_u, b_rdy_u});
    end
    total++;
    if ({v_s, v_u} !== 2'b00) begin
      bad++; $display("FAIL reset_tvalid: got %b want 00", {v_s, v_u});
    end
    total++;
    if ({d_s, d_u} !== 128'd0) begin
      bad++; $display("FAIL reset_tdata: got %h %h want 0", d_s, d_u);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({a_rdy_s, b_rdy_s, a_rdy_u, b_rdy_u} !== 4'b1111) begin
      bad++; $display("FAIL idle_tready: got %b want 1111", {a_rdy_s, b_rdy_s, a_rdy_u, b_rdy_u});
    end
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    bit          sgn;
    logic [63:0] exp;
  } vec_t;

  task automatic run_one(input logic [31:0] x, input logic [31:0] y, input string tag);
    bit busy_ok, pulse;
    logic [63:0] ds, du, es, eu;
    es = model(1'b1, x, y);
    eu = model(1'b0, x, y);
    issue(x, y, 1'b0);
    collect(busy_ok, pulse, ds, du);
    total++;
    if (busy_ok !== 1'b1) begin
      bad++; $display("FAIL %s_busy %h/%h: got early tvalid or tready want quiet", tag, x, y);
    end
    total++;
    if (pulse !== 1'b1) begin
      bad++; $display("FAIL %s_latency %h/%h: got no tvalid at k+%0d want 1", tag, x, y, W + 1);
    end
    total++;
    if (ds !== es) begin
      bad++; $display("FAIL %s_signed %h/%h: got %h want %h", tag, x, y, ds, es);
    end
    total++;
    if (du !== eu) begin
      bad++; $display("FAIL %s_unsigned %h/%h: got %h want %h", tag, x, y, du, eu);
    end
    @(posedge clk); #1;
    total++;
    if ({v_s, v_u} !== 2'b00) begin
      bad++; $display("FAIL %s_pulse_end %h/%h: got %b want 00", tag, x, y, {v_s, v_u});
    end
  endtask

  task automatic test_directed();
    vec_t tbl[7];
    tbl[0] = '{32'd100,        32'd7,          1'b0, 64'h0000000E_00000002};
    tbl[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 64'hFFFFFFFD_FFFFFFFF};
    tbl[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 64'hFFFFFFFD_00000001};
    tbl[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 64'h80000000_00000000};
    tbl[4] = '{32'hFFFF_FFFF,  32'd2,          1'b0, 64'h7FFFFFFF_00000001};
    tbl[5] = '{32'd5,          32'd0,          1'b1, 64'hFFFFFFFF_00000005};
    tbl[6] = '{32'd5,          32'd0,          1'b0, 64'hFFFFFFFF_00000005};
    for (int i = 0; i < 7; i++) begin
      logic [63:0] got;
      run_one(tbl[i].x, tbl[i].y, "dir");
      got = tbl[i].sgn ? d_s : d_u;
      total++;
      if (got !== tbl[i].exp) begin
        bad++; $display("FAIL dir_const%0d: got %h want %h", i, got, tbl[i].exp);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [31:0] x, y;
      x = (i % 6 == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       y = 32'd0;
        1:       y = $urandom_range(1, 15);
        2:       y = 32'hFFFF_FFFF;
        3:       y = $urandom >> $urandom_range(0, 31);
        default: y = $urandom;
      endcase
      run_one(x, y, "rnd");
    end
  endtask

  task automatic test_handshake();
    bit busy_ok, pulse;
    logic [63:0] ds, du;
    a = 32'd50; b = 32'd6; a_v = 1'b1; b_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if ({a_rdy_s, b_rdy_s, a_rdy_u, b_rdy_u, v_s, v_u} !== 6'b111100) begin
        bad++; $display("FAIL half_valid%0d: got rdy/vld %b want 111100", i,
                        {a_rdy_s, b_rdy_s, a_rdy_u, b_rdy_u, v_s, v_u});
      end
    end
    issue(32'd50, 32'd6, 1'b1);
    a = 32'hFFFF_FF9C; b = 32'd9;
    collect(busy_ok, pulse, ds, du);
    total++;
    if ({busy_ok, pulse} !== 2'b11) begin
      bad++; $display("FAIL hold_timing: got busy_ok,pulse %b want 11", {busy_ok, pulse});
    end
    total++;
    if ({ds, du} !== {model(1'b1, 32'd50, 32'd6), model(1'b0, 32'd50, 32'd6)}) begin
      bad++; $display("FAIL hold_first: got %h %h want 50/6 result", ds, du);
    end
    @(posedge clk); #1;
    a_v = 1'b0; b_v = 1'b0;
    total++;
    if ({a_rdy_s, a_rdy_u, v_s, v_u} !== 4'b0000) begin
      bad++; $display("FAIL hold_reaccept: got rdy/vld %b want 0000", {a_rdy_s, a_rdy_u, v_s, v_u});
    end
    collect(busy_ok, pulse, ds, du);
    total++;
    if ({busy_ok, pulse} !== 2'b11) begin
      bad++; $display("FAIL hold2_timing: got busy_ok,pulse %b want 11", {busy_ok, pulse});
    end
    total++;
    if ({ds, du} !== {model(1'b1, 32'hFFFF_FF9C, 32'd9), model(1'b0, 32'hFFFF_FF9C, 32'd9)}) begin
      bad++; $display("FAIL hold_second: got %h %h want %h %h", ds, du,
                      model(1'b1, 32'hFFFF_FF9C, 32'd9), model(1'b0, 32'hFFFF_FF9C, 32'd9));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    bit quiet;
    issue(32'd1000, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({a_rdy_s, b_rdy_s, a_rdy_u, b_rdy_u} !== 4'b0000) begin
      bad++; $display("FAIL midrst_tready: got %b want 0000", {a_rdy_s, b_rdy_s, a_rdy_u, b_rdy_u});
    end
    total++;
    if ({d_s, d_u} !== 128'd0) begin
      bad++; $display("FAIL midrst_tdata: got %h %h want 0", d_s, d_u);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({a_rdy_s, b_rdy_s, a_rdy_u, b_rdy_u} !== 4'b1111) begin
      bad++; $display("FAIL midrst_release: got %b want 1111", {a_rdy_s, b_rdy_s, a_rdy_u, b_rdy_u});
    end
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (v_s || v_u) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1) begin
      bad++; $display("FAIL midrst_no_pulse: got tvalid after abort want none");
    end
    run_one(32'd9, 32'd3, "after_rst");
    total++;
    if ({d_s, d_u} !== {64'h00000003_00000000, 64'h00000003_00000000}) begin
      bad++; $display("FAIL after_rst_const: got %h %h want 00000003_00000000", d_s, d_u);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_handshake();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
